// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for data_memory_pipelined and mem_lane_align:
//   - access size encodings (word / half / byte / reserved)
//   - controller state encodings
//   - byte-enable width
//   - helper that decides whether an access is misaligned
// -----------------------------------------------------------------------------
package mem_pkg;

  localparam int BE_W = 4;

  typedef enum logic [1:0] {
    SZ_WORD = 2'd0,
    SZ_HALF = 2'd1,
    SZ_BYTE = 2'd2,
    SZ_RSVD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Reserved size is reported as misaligned so it never touches memory.
  function automatic logic access_misaligned(input logic [1:0] size,
                                             input logic [1:0] offset);
    logic mis;
    case (size_e'(size))
      SZ_WORD: mis = (offset != 2'b00);
      SZ_HALF: mis = offset[0];
      SZ_BYTE: mis = 1'b0;
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// -----------------------------------------------------------------------------
// mem_lane_align
// Combinational big-endian lane steering for a 32-bit word.
//   size_i       access size (mem_pkg::size_e encoding)
//   offset_i     byte offset within the word (Address[1:0])
//   unsigned_i   1 = zero-extend loads, 0 = sign-extend
//   w_data_i     store data, low-order bytes used
//   rd_word_i    word read from the array
//   be_o         byte enables, bit 3 = bits [31:24] (offset 0)
//   misaligned_o access misaligned or reserved size
//   wr_word_o    store data replicated onto every lane
//   ld_data_o    extracted and extended load value (0 when misaligned)
// -----------------------------------------------------------------------------
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]      size_i,
  input  logic [1:0]      offset_i,
  input  logic            unsigned_i,
  input  logic [31:0]     w_data_i,
  input  logic [31:0]     rd_word_i,
  output logic [BE_W-1:0] be_o,
  output logic            misaligned_o,
  output logic [31:0]     wr_word_o,
  output logic [31:0]     ld_data_o
);

  logic        mis_s;
  logic [31:0] byte_sh_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  assign mis_s     = access_misaligned(size_i, offset_i);
  // Offset 0 lives in the top byte, so shift right by 8*(3-offset).
  assign byte_sh_s = rd_word_i >> {~offset_i, 3'b000};
  assign byte_s    = byte_sh_s[7:0];
  assign half_s    = offset_i[1] ? rd_word_i[15:0] : rd_word_i[31:16];

  // Byte enables, lane replication and load extension per access size.
  always_comb begin
    be_o         = 4'b0000;
    wr_word_o    = w_data_i;
    ld_data_o    = 32'h0000_0000;
    misaligned_o = mis_s;
    case (size_e'(size_i))
      SZ_WORD: begin
        be_o      = 4'b1111;
        wr_word_o = w_data_i;
        ld_data_o = rd_word_i;
      end
      SZ_HALF: begin
        be_o      = offset_i[1] ? 4'b0011 : 4'b1100;
        wr_word_o = {2{w_data_i[15:0]}};
        ld_data_o = {{16{~unsigned_i & half_s[15]}}, half_s};
      end
      SZ_BYTE: begin
        be_o      = 4'b1000 >> offset_i;
        wr_word_o = {4{w_data_i[7:0]}};
        ld_data_o = {{24{~unsigned_i & byte_s[7]}}, byte_s};
      end
      default: begin
        be_o      = 4'b0000;
        wr_word_o = w_data_i;
        ld_data_o = 32'h0000_0000;
      end
    endcase
    if (mis_s) begin
      be_o      = 4'b0000;
      ld_data_o = 32'h0000_0000;
    end else begin
      be_o      = be_o;
      ld_data_o = ld_data_o;
    end
  end

endmodule

// File: rtl/data_memory_pipelined.sv
// -----------------------------------------------------------------------------
// data_memory_pipelined
// Byte-addressable big-endian data memory for the MEM stage with a
// request/ready handshake, programmable wait states and a post-reset clear.
//   Clock       rising-edge clock
//   Reset       synchronous active-high reset
//   Req         request valid, accepted on an edge with Req && Ready
//   W_en        1 = store, 0 = load
//   Size        0 word, 1 half, 2 byte, 3 reserved (misaligned)
//   Unsigned    loads: 1 zero-extend, 0 sign-extend
//   Address     byte address, wraps modulo 4*DEPTH_WORDS
//   W_data      store data (low-order bytes)
//   Ready       request can be accepted this cycle
//   R_valid     one-cycle response pulse
//   R_data      load result (0 for stores and misaligned accesses)
//   Misaligned  response flag for misaligned / reserved-size accesses
// Latency from accept edge to the first edge seeing R_valid is WAIT_STATES+2.
// -----------------------------------------------------------------------------
module data_memory_pipelined
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS    = 256,
  parameter int ADDR_W         = 32,
  parameter int WAIT_STATES    = 0,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Req,
  input  logic              W_en,
  input  logic [1:0]        Size,
  input  logic              Unsigned,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       W_data,
  output logic              Ready,
  output logic              R_valid,
  output logic [31:0]       R_data,
  output logic              Misaligned
);

  localparam int               IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [3:0]       WAIT_LOAD = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH_WORDS - 1);
  localparam state_e           RST_STATE = (CLEAR_ON_RESET != 1'b0) ? ST_CLEAR : ST_IDLE;

  logic [31:0] mem_q [DEPTH_WORDS];

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [IDX_W+1:0]  addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              ready_q, ready_d;
  logic              rvalid_q, rvalid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              mis_q, mis_d;

  logic              mem_we_s;
  logic [IDX_W-1:0]  mem_idx_s;
  logic [31:0]       mem_wdata_s;
  logic [IDX_W-1:0]  word_idx_s;
  logic [31:0]       rd_word_s;
  logic [31:0]       merged_s;
  logic [BE_W-1:0]   be_s;
  logic              lane_mis_s;
  logic [31:0]       wr_word_s;
  logic [31:0]       ld_data_s;
  logic              unused_addr_s;

  // Address bits above the decoded range are ignored (aliasing).
  assign unused_addr_s = ^Address[ADDR_W-1:IDX_W+2];

  assign word_idx_s = addr_q[IDX_W+1:2];
  assign rd_word_s  = mem_q[word_idx_s];

  mem_lane_align u_lane_align (
    .size_i       (size_q),
    .offset_i     (addr_q[1:0]),
    .unsigned_i   (uns_q),
    .w_data_i     (wdata_q),
    .rd_word_i    (rd_word_s),
    .be_o         (be_s),
    .misaligned_o (lane_mis_s),
    .wr_word_o    (wr_word_s),
    .ld_data_o    (ld_data_s)
  );

  // Merge enabled store lanes into the current word; other lanes preserved.
  always_comb begin
    merged_s = rd_word_s;
    for (int i = 0; i < BE_W; i++) begin
      if (be_s[i]) begin
        merged_s[8*i +: 8] = wr_word_s[8*i +: 8];
      end else begin
        merged_s[8*i +: 8] = rd_word_s[8*i +: 8];
      end
    end
  end

  // Controller next-state, registered-output next values and array write port.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    ready_d     = 1'b0;
    rvalid_d    = 1'b0;
    rdata_d     = 32'h0000_0000;
    mis_d       = 1'b0;
    mem_we_s    = 1'b0;
    mem_idx_s   = ptr_q;
    mem_wdata_s = 32'h0000_0000;
    case (state_q)
      ST_CLEAR: begin
        mem_we_s    = 1'b1;
        mem_idx_s   = ptr_q;
        mem_wdata_s = 32'h0000_0000;
        ptr_d       = ptr_q + IDX_W'(1);
        if (ptr_q == LAST_IDX) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      ST_IDLE: begin
        // ready_q guards the first IDLE cycle after a reset without clear.
        if (Req && ready_q) begin
          we_d    = W_en;
          size_d  = Size;
          uns_d   = Unsigned;
          addr_d  = Address[IDX_W+1:0];
          wdata_d = W_data;
          cnt_d   = WAIT_LOAD;
          state_d = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
        end else begin
          ready_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d  = ST_IDLE;
        ready_d  = 1'b1;
        rvalid_d = 1'b1;
        mis_d    = lane_mis_s;
        if (lane_mis_s) begin
          rdata_d = 32'h0000_0000;
        end else if (we_q) begin
          mem_we_s    = 1'b1;
          mem_idx_s   = word_idx_s;
          mem_wdata_s = merged_s;
        end else begin
          rdata_d = ld_data_s;
        end
      end
      default: begin
        state_d = RST_STATE;
      end
    endcase
  end

  // Controller and output registers with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= RST_STATE;
      cnt_q    <= 4'd0;
      ptr_q    <= '0;
      we_q     <= 1'b0;
      size_q   <= 2'd0;
      uns_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 32'h0000_0000;
      ready_q  <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= 32'h0000_0000;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      we_q     <= we_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      mis_q    <= mis_d;
    end
  end

  // Array write; a reset on the commit edge discards the pending store.
  always_ff @(posedge Clock) begin
    if (mem_we_s && !Reset) begin
      mem_q[mem_idx_s] <= mem_wdata_s;
    end
  end

  assign Ready      = ready_q;
  assign R_valid    = rvalid_q;
  assign R_data     = rdata_q;
  assign Misaligned = mis_q;

endmodule

// File: tb/tb_data_memory_pipelined.sv
module tb_data_memory_pipelined;

  localparam int DEPTH = 16;
  localparam int WS    = 3;
  localparam int MEMB  = 4 * DEPTH;
  localparam int LAT   = WS + 2;

  logic        Clock = 1'b0;
  logic        Reset, Req, W_en, Unsigned, Ready, R_valid, Misaligned;
  logic [1:0]  Size;
  logic [31:0] Address, W_data, R_data;

  always #5 Clock = ~Clock;

  data_memory_pipelined #(
    .DEPTH_WORDS(DEPTH), .ADDR_W(32), .WAIT_STATES(WS), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Req(Req), .W_en(W_en), .Size(Size),
    .Unsigned(Unsigned), .Address(Address), .W_data(W_data), .Ready(Ready),
    .R_valid(R_valid), .R_data(R_data), .Misaligned(Misaligned)
  );

  // Behavioural model: a flat byte array plus a few cycle counters.
  logic [7:0]  m_bytes [MEMB];
  int          clr_left, pend_left, cyc, acc_cyc;
  bit          pend, accepted;
  bit          p_we, p_uns, p_pin, p_pin_mis;
  logic [1:0]  p_sz;
  logic [31:0] p_addr, p_wd, p_pin_data;
  bit          exp_ready, exp_rvalid, exp_mis, exp_pin, exp_pin_mis;
  logic [31:0] exp_rdata, exp_pin_data;
  bit          s_pin, s_pin_mis;
  logic [31:0] s_pin_data;
  int          n_checks, n_fail;

  task automatic model_access(output logic [31:0] data, output bit mis);
    int base, nb;
    logic [31:0] v;
    base = int'(p_addr % MEMB);
    mis  = (p_sz == 2'd3) || (p_sz == 2'd0 && p_addr[1:0] != 2'd0) ||
           (p_sz == 2'd1 && p_addr[0]);
    data = 32'd0;
    if (!mis) begin
      nb = (p_sz == 2'd0) ? 4 : ((p_sz == 2'd1) ? 2 : 1);
      if (p_we) begin
        for (int i = 0; i < nb; i++) m_bytes[base + i] = 8'(p_wd >> (8 * (nb - 1 - i)));
      end else begin
        v = 32'd0;
        for (int i = 0; i < nb; i++) v = (v << 8) | 32'(m_bytes[base + i]);
        if (!p_uns && nb < 4 && v[8 * nb - 1]) v = v | (32'hFFFF_FFFF << (8 * nb));
        data = v;
      end
    end
  endtask

  task automatic model_edge();
    accepted = 1'b0;
    if (Reset) begin
      for (int i = 0; i < MEMB; i++) m_bytes[i] = 8'd0;
      clr_left = DEPTH; pend = 1'b0;
      exp_ready = 1'b0; exp_rvalid = 1'b0; exp_rdata = 32'd0; exp_mis = 1'b0; exp_pin = 1'b0;
    end else begin
      exp_rvalid = 1'b0; exp_rdata = 32'd0; exp_mis = 1'b0; exp_pin = 1'b0;
      if (clr_left > 0) begin
        clr_left--;
        exp_ready = (clr_left == 0);
      end else if (pend) begin
        pend_left--;
        if (pend_left == 0) begin
          model_access(exp_rdata, exp_mis);
          exp_rvalid = 1'b1; exp_ready = 1'b1; pend = 1'b0;
          exp_pin = p_pin; exp_pin_data = p_pin_data; exp_pin_mis = p_pin_mis;
        end
      end else if (exp_ready && Req) begin
        pend = 1'b1; pend_left = WS + 1; accepted = 1'b1; acc_cyc = cyc;
        p_we = W_en; p_sz = Size; p_uns = Unsigned; p_addr = Address; p_wd = W_data;
        p_pin = s_pin; p_pin_data = s_pin_data; p_pin_mis = s_pin_mis;
        exp_ready = 1'b0;
      end else begin
        exp_ready = 1'b1;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: DUT=%h expected=%h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Single compare process: outputs vs model every cycle, plus literal pins.
  initial begin
    n_checks = 0; n_fail = 0;
    forever begin
      @(negedge Clock);
      chk("ready", 32'(Ready), 32'(exp_ready));
      chk("r_valid", 32'(R_valid), 32'(exp_rvalid));
      chk("r_data", R_data, exp_rdata);
      chk("misaligned", 32'(Misaligned), 32'(exp_mis));
      if (exp_pin) begin
        chk("pin_data", R_data, exp_pin_data);
        chk("pin_mis", 32'(Misaligned), 32'(exp_pin_mis));
      end
      if (R_valid === 1'b1) chk("latency", 32'(cyc + 1 - acc_cyc), 32'(LAT));
    end
  end

  task automatic step();
    @(posedge Clock);
    cyc++;
    model_edge();
    @(negedge Clock);
  endtask

  task automatic do_req(input bit we, input logic [1:0] sz, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input bit pin, input logic [31:0] pin_data, input bit pin_mis);
    int n;
    W_en = we; Size = sz; Unsigned = uns; Address = addr; W_data = wd; Req = 1'b1;
    s_pin = pin; s_pin_data = pin_data; s_pin_mis = pin_mis;
    n = 0;
    do begin
      step();
      n++;
    end while (!accepted && n < 200);
    if (!accepted) begin
      $display("FAIL req_timeout: request at addr %h never accepted", addr);
      $fatal(1, "request timeout");
    end
    Req = 1'b0; s_pin = 1'b0;
  endtask

  initial begin
    logic [31:0] addr;
    int          r;
    logic [1:0]  sz;
    cyc = 0; acc_cyc = 0; pend = 1'b0; clr_left = 0;
    exp_ready = 1'b0; exp_rvalid = 1'b0; exp_rdata = 32'd0; exp_mis = 1'b0; exp_pin = 1'b0;
    s_pin = 1'b0; s_pin_data = 32'd0; s_pin_mis = 1'b0;
    Reset = 1'b1; Req = 1'b0; W_en = 1'b0; Size = 2'd0; Unsigned = 1'b0;
    Address = 32'd0; W_data = 32'd0;
    step(); step();
    Reset = 1'b0;

    // Clear sweep, then every word reads back zero.
    for (int a = 0; a < 64; a += 4) do_req(1'b0, 2'd0, 1'b0, 32'(a), 32'd0, 1'b1, 32'h0, 1'b0);

    // Big-endian lanes, signed and unsigned loads.
    do_req(1'b1, 2'd0, 1'b0, 32'd0, 32'hCADF_EB89, 1'b1, 32'h0, 1'b0);
    do_req(1'b0, 2'd2, 1'b0, 32'd0, 32'd0, 1'b1, 32'hFFFF_FFCA, 1'b0);
    do_req(1'b0, 2'd2, 1'b0, 32'd1, 32'd0, 1'b1, 32'hFFFF_FFDF, 1'b0);
    do_req(1'b0, 2'd2, 1'b0, 32'd2, 32'd0, 1'b1, 32'hFFFF_FFEB, 1'b0);
    do_req(1'b0, 2'd2, 1'b0, 32'd3, 32'd0, 1'b1, 32'hFFFF_FF89, 1'b0);
    do_req(1'b0, 2'd2, 1'b1, 32'd1, 32'd0, 1'b1, 32'h0000_00DF, 1'b0);
    do_req(1'b0, 2'd1, 1'b0, 32'd2, 32'd0, 1'b1, 32'hFFFF_EB89, 1'b0);
    do_req(1'b0, 2'd1, 1'b1, 32'd0, 32'd0, 1'b1, 32'h0000_CADF, 1'b0);

    // Partial stores preserve the other lanes.
    do_req(1'b1, 2'd0, 1'b0, 32'd24, 32'hBEAD_BEAD, 1'b1, 32'h0, 1'b0);
    do_req(1'b1, 2'd1, 1'b0, 32'd26, 32'h0000_DDDD, 1'b1, 32'h0, 1'b0);
    do_req(1'b1, 2'd2, 1'b0, 32'd25, 32'h0000_00E0, 1'b1, 32'h0, 1'b0);
    do_req(1'b0, 2'd0, 1'b0, 32'd24, 32'd0, 1'b1, 32'hBEE0_DDDD, 1'b0);

    // Busy-window Req pulses are ignored; back-to-back requests.
    do_req(1'b0, 2'd0, 1'b0, 32'd0, 32'd0, 1'b1, 32'hCADF_EB89, 1'b0);
    W_en = 1'b1; Size = 2'd0; Address = 32'd0; W_data = 32'hFFFF_FFFF; Req = 1'b1;
    step(); Req = 1'b0; step(); Req = 1'b1; step(); Req = 1'b0;
    do_req(1'b0, 2'd0, 1'b0, 32'd0, 32'd0, 1'b1, 32'hCADF_EB89, 1'b0);
    do_req(1'b0, 2'd0, 1'b0, 32'd24, 32'd0, 1'b1, 32'hBEE0_DDDD, 1'b0);
    do_req(1'b0, 2'd0, 1'b0, 32'd4, 32'd0, 1'b1, 32'h0, 1'b0);

    // Misaligned accesses leave memory untouched.
    do_req(1'b0, 2'd0, 1'b0, 32'd2, 32'd0, 1'b1, 32'h0, 1'b1);
    do_req(1'b1, 2'd1, 1'b0, 32'd5, 32'h0000_1234, 1'b1, 32'h0, 1'b1);
    do_req(1'b1, 2'd3, 1'b0, 32'd8, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b1);
    do_req(1'b0, 2'd0, 1'b0, 32'd0, 32'd0, 1'b1, 32'hCADF_EB89, 1'b0);
    do_req(1'b0, 2'd0, 1'b0, 32'd4, 32'd0, 1'b1, 32'h0, 1'b0);
    do_req(1'b0, 2'd0, 1'b0, 32'd8, 32'd0, 1'b1, 32'h0, 1'b0);

    // Reset during WAIT of a store drops it; clear runs again; aliasing.
    do_req(1'b1, 2'd0, 1'b0, 32'd12, 32'h1234_5678, 1'b0, 32'h0, 1'b0);
    step();
    Reset = 1'b1; step(); Reset = 1'b0;
    do_req(1'b0, 2'd0, 1'b0, 32'd12, 32'd0, 1'b1, 32'h0, 1'b0);
    do_req(1'b1, 2'd0, 1'b0, 32'd64, 32'hA5A5_1234, 1'b1, 32'h0, 1'b0);
    do_req(1'b0, 2'd0, 1'b0, 32'd0, 32'd0, 1'b1, 32'hA5A5_1234, 1'b0);
    do_req(1'b0, 2'd1, 1'b1, 32'd66, 32'd0, 1'b1, 32'h0000_1234, 1'b0);
    repeat (6) step();

    // Randomized traffic with one mid-run reset.
    for (int c = 0; c < 600; c++) begin
      r  = $urandom_range(0, 9);
      sz = (r < 4) ? 2'd0 : ((r < 7) ? 2'd1 : ((r < 9) ? 2'd2 : 2'd3));
      addr = 32'($urandom_range(0, 127));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd0) addr = addr & 32'hFFFF_FFFC;
        if (sz == 2'd1) addr = addr & 32'hFFFF_FFFE;
      end
      Req = ($urandom_range(0, 1) == 1); W_en = ($urandom_range(0, 2) == 0);
      Size = sz; Unsigned = ($urandom_range(0, 1) == 1); Address = addr;
      W_data = $urandom;
      Reset = (c == 300);
      step();
    end
    Reset = 1'b0; Req = 1'b0;
    repeat (10) step();
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
